shared_mem_arbiter: RTL and testbench

- Shares one external shared-memory port among NUM_CORES cores.
- Each core issues requests with a hold-until-ready handshake: request, wren, rden, addr, write_val are held until ready is seen high.
- The block picks one requester using a round-robin scheme and drives the shared memory port with that core's signals.
- It returns ready to the granted core. Read data is broadcast to all cores, and only the granted core consumes it.
- Sits at the top level, between the core instances and the shared memory controller.

---
 rtl/shared_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one 16-bit memory port among NUM_CORES cores.
// Define SHARED_ARB_BURST_EN to let a granted core complete up to MAX_BURST back-to-back accesses.
module shared_mem_arbiter #(
  parameter  int unsigned NUM_CORES = 4,
  parameter  int unsigned ID_WIDTH  = $clog2(NUM_CORES),
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_request_i,
  input  logic [NUM_CORES-1:0]        core_wren_i,
  input  logic [NUM_CORES-1:0]        core_rden_i,
  input  logic [DATA_W*NUM_CORES-1:0] core_addr_i,
  input  logic [DATA_W*NUM_CORES-1:0] core_write_val_i,
  output logic [NUM_CORES-1:0]        core_ready_o,
  output logic [DATA_W-1:0]           core_read_val_o,
  output logic                        mem_request_o,
  output logic                        mem_wren_o,
  output logic                        mem_rden_o,
  output logic [DATA_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_write_val_o,
  input  logic                        mem_ready_i,
  input  logic [DATA_W-1:0]           mem_read_val_i
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  if (NUM_CORES < 2 || MAX_BURST < 1) begin : g_param_check
    $error("shared_mem_arbiter: NUM_CORES must be >= 2 and MAX_BURST >= 1");
  end

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

`ifdef SHARED_ARB_BURST_EN
  localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

  logic [DATA_W-1:0]   addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]   wdata_arr [NUM_CORES];
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] scan_idx;
  logic                winner_valid;
  logic [ID_WIDTH-1:0] next_id;
  logic                gnt_req;

  // Unpack the per-core address and write-data slices
  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      addr_arr[i]  = core_addr_i[i*DATA_W +: DATA_W];
      wdata_arr[i] = core_write_val_i[i*DATA_W +: DATA_W];
    end
  end

  // First requester at or after rr_ptr; scanning downward leaves the lowest offset as winner
  always_comb begin
    winner       = rr_ptr_q;
    winner_valid = 1'b0;
    scan_idx     = rr_ptr_q;
    for (int unsigned k = NUM_CORES; k > 0; k--) begin
      scan_idx = ID_WIDTH'((32'(rr_ptr_q) + k - 1) % NUM_CORES);
      if (core_request_i[scan_idx]) begin
        winner       = scan_idx;
        winner_valid = 1'b1;
      end
    end
  end

  assign next_id         = (grant_id_q == ID_WIDTH'(NUM_CORES - 1)) ? '0 : grant_id_q + ID_WIDTH'(1);
  assign gnt_req         = core_request_i[grant_id_q];
  assign core_read_val_o = reset ? '0 : mem_read_val_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
`ifdef SHARED_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef SHARED_ARB_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    rr_ptr_d        = rr_ptr_q;
`ifdef SHARED_ARB_BURST_EN
    burst_cnt_d     = burst_cnt_q;
`endif
    core_ready_o    = '0;
    mem_request_o   = 1'b0;
    mem_wren_o      = 1'b0;
    mem_rden_o      = 1'b0;
    mem_addr_o      = '0;
    mem_write_val_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (winner_valid) begin
          grant_id_d  = winner;
          state_d     = ST_ACCESS;
`ifdef SHARED_ARB_BURST_EN
          burst_cnt_d = '0;
`endif
        end
      end

      ST_ACCESS: begin
        mem_request_o   = gnt_req;
        mem_wren_o      = gnt_req & core_wren_i[grant_id_q];
        mem_rden_o      = gnt_req & core_rden_i[grant_id_q];
        mem_addr_o      = addr_arr[grant_id_q];
        mem_write_val_o = wdata_arr[grant_id_q];

        if (!gnt_req) begin
          // Withdrawn before any access leaves the pointer; ending a burst advances it
          state_d = ST_IDLE;
`ifdef SHARED_ARB_BURST_EN
          if (burst_cnt_q != '0) begin
            rr_ptr_d = next_id;
          end
`endif
        end else if (mem_ready_i) begin
          core_ready_o[grant_id_q] = 1'b1;
`ifdef SHARED_ARB_BURST_EN
          if (32'(burst_cnt_q) < MAX_BURST - 1) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
          end else begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_id;
          end
`else
          state_d  = ST_IDLE;
          rr_ptr_d = next_id;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model and a shadow memory.
`timescale 1ns/1ps
module tb_shared_mem_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk;
  logic           reset;
  logic [N-1:0]   core_request, core_wren, core_rden;
  logic [N*W-1:0] core_addr, core_write_val;
  logic [N-1:0]   core_ready;
  logic [W-1:0]   core_read_val;
  logic           mem_request, mem_wren, mem_rden;
  logic [W-1:0]   mem_addr, mem_write_val;
  logic           mem_ready;
  logic [W-1:0]   mem_read_val;

  int checks;
  int fails;
  int model_rr;

  // Memory device contents (written only by the memory process) and the bench's shadow copy
  logic [W-1:0] mem_store [65536];
  bit           mem_valid [65536];
  logic [W-1:0] ref_mem   [65536];
  bit           ref_valid [65536];

  shared_mem_arbiter #(.NUM_CORES(N), .MAX_BURST(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .core_request_i   (core_request),
    .core_wren_i      (core_wren),
    .core_rden_i      (core_rden),
    .core_addr_i      (core_addr),
    .core_write_val_i (core_write_val),
    .core_ready_o     (core_ready),
    .core_read_val_o  (core_read_val),
    .mem_request_o    (mem_request),
    .mem_wren_o       (mem_wren),
    .mem_rden_o       (mem_rden),
    .mem_addr_o       (mem_addr),
    .mem_write_val_o  (mem_write_val),
    .mem_ready_i      (mem_ready),
    .mem_read_val_i   (mem_read_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations read back as addr ^ 0xFEFF (0x4010 -> 0xBEEF)
  always @(posedge clk) begin
    if (mem_request && mem_ready) begin
      if (mem_wren) begin
        mem_store[mem_addr] <= mem_write_val;
        mem_valid[mem_addr] <= 1'b1;
      end
      if (mem_rden) begin
        mem_read_val <= mem_valid[mem_addr] ? mem_store[mem_addr] : (mem_addr ^ 16'hFEFF);
      end
    end
  end

  function automatic logic [W-1:0] ref_read(input logic [W-1:0] a);
    return ref_valid[a] ? ref_mem[a] : (a ^ 16'hFEFF);
  endfunction

  function automatic int pick(input logic [N-1:0] req, input int rr);
    for (int k = 0; k < N; k++) begin
      if (req[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic rq, input logic wr, input logic rd,
                          input logic [W-1:0] a, input logic [W-1:0] d);
    core_request[c]      = rq;
    core_wren[c]         = wr;
    core_rden[c]         = rd;
    core_addr[c*W +: W]  = a;
    core_write_val[c*W +: W] = d;
  endtask

  task automatic clear_cores();
    for (int c = 0; c < N; c++) set_core(c, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b1, 1'b0, 16'h1111 * 16'(c + 1), 16'hABCD);
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", core_ready); end
    checks++; if ({mem_request, mem_wren, mem_rden} !== 3'b000) begin fails++; $display("FAIL reset_mem_ctrl: got %b want 000", {mem_request, mem_wren, mem_rden}); end
    checks++; if (mem_addr !== 16'h0 || mem_write_val !== 16'h0) begin fails++; $display("FAIL reset_mem_bus: got addr %h data %h want 0", mem_addr, mem_write_val); end
    checks++; if (core_read_val !== 16'h0) begin fails++; $display("FAIL reset_read_val: got %h want 0000", core_read_val); end
    next_cycle();
    clear_cores();
    reset    = 1'b0;
    model_rr = 0;
  endtask

  task automatic test_single_read();
    next_cycle();
    set_core(2, 1'b1, 1'b0, 1'b1, 16'h4010, 16'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_request !== 1'b0 || core_ready !== 4'b0000) begin fails++; $display("FAIL single_arb_cycle: got req %b ready %b want 0 0000", mem_request, core_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (mem_rden !== 1'b1 || mem_wren !== 1'b0) begin fails++; $display("FAIL single_rden: got rden %b wren %b want 1 0", mem_rden, mem_wren); end
    checks++; if (mem_addr !== 16'h4010) begin fails++; $display("FAIL single_addr: got %h want 4010", mem_addr); end
    checks++; if (core_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", core_ready); end
    model_rr = 3;
    next_cycle();
    set_core(2, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (core_read_val !== 16'hBEEF) begin fails++; $display("FAIL single_read_val: got %h want beef", core_read_val); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] data [N];
    int exp;
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < N; c++) begin
      data[c] = 16'($urandom);
      set_core(c, 1'b1, 1'b1, 1'b0, 16'h0200 + 16'(c), data[c]);
    end
    mem_ready = 1'b1;
    next_cycle();
    reset    = 1'b0;
    model_rr = 0;
    for (int g = 0; g < 8; g++) begin
      exp = pick(core_request, model_rr);
      @(negedge clk);
      checks++; if (mem_request !== 1'b0 || core_ready !== 4'b0000) begin fails++; $display("FAIL rr_idle_%0d: got req %b ready %b want 0 0000", g, mem_request, core_ready); end
      next_cycle();
      @(negedge clk);
      checks++; if (core_ready !== 4'(1 << exp)) begin fails++; $display("FAIL rr_grant_%0d: got %b want %b", g, core_ready, 4'(1 << exp)); end
      checks++; if (mem_wren !== 1'b1 || mem_addr !== 16'h0200 + 16'(exp)) begin fails++; $display("FAIL rr_addr_%0d: got wren %b addr %h want 1 %h", g, mem_wren, mem_addr, 16'h0200 + 16'(exp)); end
      checks++; if (mem_write_val !== data[exp]) begin fails++; $display("FAIL rr_wdata_%0d: got %h want %h", g, mem_write_val, data[exp]); end
      ref_mem[16'h0200 + 16'(exp)]   = data[exp];
      ref_valid[16'h0200 + 16'(exp)] = 1'b1;
      model_rr = (exp + 1) % N;
      next_cycle();
      data[exp] = 16'($urandom);
      set_core(exp, 1'b1, 1'b1, 1'b0, 16'h0200 + 16'(exp), data[exp]);
    end
    clear_cores();
  endtask

  task automatic test_slow_memory();
    next_cycle();
    set_core(1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000) begin fails++; $display("FAIL slow_idle: got %b want 0000", core_ready); end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (mem_request !== 1'b1 || mem_addr !== 16'h1234 || core_ready !== 4'b0000) begin
        fails++; $display("FAIL slow_wait_%0d: got req %b addr %h ready %b want 1 1234 0000", i, mem_request, mem_addr, core_ready);
      end
    end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (core_ready !== 4'b0010) begin fails++; $display("FAIL slow_ready: got %b want 0010", core_ready); end
    model_rr = 2;
    next_cycle();
    set_core(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000) begin fails++; $display("FAIL slow_single_strobe: got %b want 0000", core_ready); end
    checks++; if (core_read_val !== ref_read(16'h1234)) begin fails++; $display("FAIL slow_read_val: got %h want %h", core_read_val, ref_read(16'h1234)); end
  endtask

  task automatic test_withdrawn();
    int exp;
    next_cycle();
    set_core(3, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h5A5A);
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000) begin fails++; $display("FAIL wd_idle: got %b want 0000", core_ready); end
    next_cycle();
    set_core(3, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (mem_request !== 1'b0 || core_ready !== 4'b0000) begin fails++; $display("FAIL wd_no_access: got req %b ready %b want 0 0000", mem_request, core_ready); end
    // Pointer must still be 2, so core 3 beats core 0
    next_cycle();
    set_core(0, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0);
    set_core(3, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h5A5A);
    exp = pick(core_request, model_rr);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks++; if (core_ready !== 4'(1 << exp)) begin fails++; $display("FAIL wd_rr_kept: got %b want %b", core_ready, 4'(1 << exp)); end
    ref_mem[16'h0300] = 16'h5A5A; ref_valid[16'h0300] = 1'b1;
    model_rr = (exp + 1) % N;
    next_cycle();
    set_core(3, 1'b0, 1'b0, 1'b0, '0, '0);
    exp = pick(core_request, model_rr);
    next_cycle();
    @(negedge clk);
    checks++; if (core_ready !== 4'(1 << exp)) begin fails++; $display("FAIL wd_next_grant: got %b want %b", core_ready, 4'(1 << exp)); end
    model_rr = (exp + 1) % N;
    next_cycle();
    clear_cores();
  endtask

  task automatic test_reset_mid_access();
    next_cycle();
    set_core(2, 1'b1, 1'b0, 1'b1, 16'h0777, 16'h0);
    mem_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (mem_request !== 1'b1) begin fails++; $display("FAIL rst_mid_access: got req %b want 1", mem_request); end
    reset = 1'b1;
    #1;
    checks++; if ({mem_request, mem_rden, mem_wren} !== 3'b000 || mem_addr !== 16'h0 || core_ready !== 4'b0000) begin
      fails++; $display("FAIL rst_mid_outputs: got ctrl %b addr %h ready %b want 000 0000 0000", {mem_request, mem_rden, mem_wren}, mem_addr, core_ready);
    end
    next_cycle();
    for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b0, 1'b1, 16'h0800 + 16'(c), 16'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000 || mem_request !== 1'b0) begin fails++; $display("FAIL rst_held: got ready %b req %b want 0000 0", core_ready, mem_request); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000) begin fails++; $display("FAIL rst_release_idle: got %b want 0000", core_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (core_ready !== 4'b0001) begin fails++; $display("FAIL rst_first_grant: got %b want 0001", core_ready); end
    model_rr = 1;
    next_cycle();
    clear_cores();
  endtask

`ifndef SHARED_ARB_BURST_EN
  task automatic test_random();
    bit           pend [N];
    bit           op_wr [N];
    logic [W-1:0] op_addr [N];
    logic [W-1:0] op_data [N];
    int           gnt;
    bit           rd_check;
    logic [W-1:0] exp_rdata;
    logic [N-1:0] exp_ready;
    gnt      = -1;
    rd_check = 1'b0;
    exp_rdata = '0;
    for (int c = 0; c < N; c++) pend[c] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      next_cycle();
      for (int c = 0; c < N; c++) begin
        if (!pend[c] && ($urandom % 3 == 0)) begin
          pend[c]    = 1'b1;
          op_wr[c]   = 1'($urandom);
          op_addr[c] = 16'h0100 + 16'($urandom % 16);
          op_data[c] = 16'($urandom);
        end
        if (pend[c]) set_core(c, 1'b1, op_wr[c], !op_wr[c], op_addr[c], op_data[c]);
        else         set_core(c, 1'b0, 1'b0, 1'b0, '0, '0);
      end
      mem_ready = ($urandom % 4 != 0);
      @(negedge clk);
      if (rd_check) begin
        checks++; if (core_read_val !== exp_rdata) begin fails++; $display("FAIL rnd_read_val c%0d: got %h want %h", cyc, core_read_val, exp_rdata); end
        rd_check = 1'b0;
      end
      checks++; if (mem_wren === 1'b1 && mem_rden === 1'b1) begin fails++; $display("FAIL rnd_rw_both c%0d: got wren %b rden %b want not both", cyc, mem_wren, mem_rden); end
      if (gnt < 0) begin
        checks++; if (mem_request !== 1'b0 || core_ready !== 4'b0000) begin fails++; $display("FAIL rnd_idle c%0d: got req %b ready %b want 0 0000", cyc, mem_request, core_ready); end
        gnt = pick(core_request, model_rr);
      end else begin
        exp_ready = mem_ready ? 4'(1 << gnt) : 4'b0000;
        checks++; if (mem_request !== 1'b1 || mem_addr !== op_addr[gnt] || mem_wren !== op_wr[gnt]) begin
          fails++; $display("FAIL rnd_access c%0d: got req %b addr %h wren %b want 1 %h %b", cyc, mem_request, mem_addr, mem_wren, op_addr[gnt], op_wr[gnt]);
        end
        if (op_wr[gnt]) begin
          checks++; if (mem_write_val !== op_data[gnt]) begin fails++; $display("FAIL rnd_wdata c%0d: got %h want %h", cyc, mem_write_val, op_data[gnt]); end
        end
        checks++; if (core_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, core_ready, exp_ready); end
        if (mem_ready) begin
          if (op_wr[gnt]) begin
            ref_mem[op_addr[gnt]]   = op_data[gnt];
            ref_valid[op_addr[gnt]] = 1'b1;
          end else begin
            exp_rdata = ref_read(op_addr[gnt]);
            rd_check  = 1'b1;
          end
          pend[gnt] = 1'b0;
          model_rr  = (gnt + 1) % N;
          gnt       = -1;
        end
      end
    end
    next_cycle();
    clear_cores();
  endtask
`else
  task automatic test_burst();
    next_cycle();
    reset = 1'b1;
    clear_cores();
    next_cycle();
    reset     = 1'b0;
    mem_ready = 1'b1;
    set_core(0, 1'b1, 1'b0, 1'b1, 16'h0600, 16'h0);
    set_core(1, 1'b1, 1'b0, 1'b1, 16'h0700, 16'h0);
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000) begin fails++; $display("FAIL burst_idle: got %b want 0000", core_ready); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      set_core(0, 1'b1, 1'b0, 1'b1, 16'h0600 + 16'(i), 16'h0);
      @(negedge clk);
      checks++; if (core_ready !== 4'b0001 || mem_addr !== 16'h0600 + 16'(i)) begin
        fails++; $display("FAIL burst_beat_%0d: got ready %b addr %h want 0001 %h", i, core_ready, mem_addr, 16'h0600 + 16'(i));
      end
    end
    next_cycle();
    set_core(0, 1'b1, 1'b0, 1'b1, 16'h0604, 16'h0);
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000 || mem_request !== 1'b0) begin fails++; $display("FAIL burst_end_idle: got ready %b req %b want 0000 0", core_ready, mem_request); end
    next_cycle();
    @(negedge clk);
    checks++; if (core_ready !== 4'b0010 || mem_addr !== 16'h0700) begin fails++; $display("FAIL burst_core1: got ready %b addr %h want 0010 0700", core_ready, mem_addr); end
    next_cycle();
    set_core(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000 || mem_request !== 1'b0) begin fails++; $display("FAIL burst_dead: got ready %b req %b want 0000 0", core_ready, mem_request); end
    next_cycle();
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000) begin fails++; $display("FAIL burst_rearb: got %b want 0000", core_ready); end
    for (int i = 4; i < 6; i++) begin
      next_cycle();
      set_core(0, 1'b1, 1'b0, 1'b1, 16'h0600 + 16'(i), 16'h0);
      @(negedge clk);
      checks++; if (core_ready !== 4'b0001 || mem_addr !== 16'h0600 + 16'(i)) begin
        fails++; $display("FAIL burst_resume_%0d: got ready %b addr %h want 0001 %h", i, core_ready, mem_addr, 16'h0600 + 16'(i));
      end
    end
    next_cycle();
    clear_cores();
    @(negedge clk);
    checks++; if (core_ready !== 4'b0000) begin fails++; $display("FAIL burst_done: got %b want 0000", core_ready); end
  endtask
`endif

  initial begin
    checks       = 0;
    fails        = 0;
    model_rr     = 0;
    reset        = 1'b1;
    mem_ready    = 1'b0;
    clear_cores();
    test_reset();
    test_single_read();
`ifndef SHARED_ARB_BURST_EN
    test_round_robin();
    test_slow_memory();
    test_withdrawn();
    test_reset_mid_access();
    test_random();
`else
    test_slow_memory();
    test_reset_mid_access();
    test_burst();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
